// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//   Pipeline stall/flush controller. Covers the hazards that operand forwarding
//   cannot resolve:
//     - load-use: a load in EX feeds an ID source
//     - ID-stage compare/jump: a branch or jr in ID reads a register that is
//       still being produced in EX, or by a load in MEM
//     - MDU: mfhi/mflo in ID while a multi-cycle mult/div is still running
//   It also tracks MDU occupancy and keeps a saturating count of stall cycles.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   if_id_instruction     instruction in ID (rs=[25:21], rt=[20:16])
//   id_uses_rs/rt         ID instruction reads rs / rt
//   id_is_branch          ID holds beq/bne (compared in ID)
//   id_is_jr              ID holds jr/jalr (target taken from rs in ID)
//   id_is_mfhilo          ID holds mfhi/mflo
//   id_jump_taken         ID resolved a redirect this cycle
//   id_ex_instruction     instruction in EX
//   id_ex_gpr_w_sel       EX destination select (RT/RD/RA, 0 = no write)
//   id_ex_mem_read        EX instruction is a load
//   ex_mem_instruction    instruction in MEM
//   ex_mem_gpr_w_sel      MEM destination select
//   ex_mem_mem_read       MEM instruction is a load
//   md_start              qualified mult/div enters EX this cycle
//   pc_write              1 = PC updates
//   if_id_write           1 = IF_ID latches
//   if_id_flush           1 = IF_ID loaded with nop next edge
//   id_ex_flush           1 = ID_EX loaded with bubble next edge
//   md_busy               MDU result still pending
//   stall_count           saturating count of stalled cycles
// -----------------------------------------------------------------------------
module hazard_unit #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      if_id_instruction,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_branch,
    input  logic             id_is_jr,
    input  logic             id_is_mfhilo,
    input  logic             id_jump_taken,
    input  logic [31:0]      id_ex_instruction,
    input  logic [1:0]       id_ex_gpr_w_sel,
    input  logic             id_ex_mem_read,
    input  logic [31:0]      ex_mem_instruction,
    input  logic [1:0]       ex_mem_gpr_w_sel,
    input  logic             ex_mem_mem_read,
    input  logic             md_start,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_count
);

    localparam int MD_W = $clog2(MD_LATENCY + 1);

    // Destination-select encodings; any other value means no GPR write.
    localparam logic [1:0] GPR_RT = 2'd1;
    localparam logic [1:0] GPR_RD = 2'd2;
    localparam logic [1:0] GPR_RA = 2'd3;

    // Register number written by an instruction; $0 doubles as "no write"
    // because a write to $0 can never create a hazard.
    function automatic logic [4:0] dest_reg(input logic [31:0] instr,
                                            input logic [1:0]  sel);
        case (sel)
            GPR_RT:  dest_reg = instr[20:16];
            GPR_RD:  dest_reg = instr[15:11];
            GPR_RA:  dest_reg = 5'd31;
            default: dest_reg = 5'd0;
        endcase
    endfunction

    logic [4:0]      id_rs;
    logic [4:0]      id_rt;
    logic [4:0]      ex_dest;
    logic [4:0]      mem_dest;
    logic            ex_hits_src;
    logic            mem_hits_src;
    logic            id_compares;
    logic            h_lu;
    logic            h_bex;
    logic            h_blm;
    logic            h_md;
    logic            stall;
    logic [MD_W-1:0] md_cnt;

    assign id_rs    = if_id_instruction[25:21];
    assign id_rt    = if_id_instruction[20:16];
    assign ex_dest  = dest_reg(id_ex_instruction, id_ex_gpr_w_sel);
    assign mem_dest = dest_reg(ex_mem_instruction, ex_mem_gpr_w_sel);

    // A stage "hits" ID when it writes a non-zero register that ID actually reads.
    assign ex_hits_src  = (ex_dest != 5'd0) &&
                          ((id_uses_rs && id_rs == ex_dest) ||
                           (id_uses_rt && id_rt == ex_dest));
    assign mem_hits_src = (mem_dest != 5'd0) &&
                          ((id_uses_rs && id_rs == mem_dest) ||
                           (id_uses_rt && id_rt == mem_dest));

    assign id_compares = id_is_branch || id_is_jr;

    assign h_lu  = id_ex_mem_read && ex_hits_src;
    // Branch/jr compare in ID, so even an ALU result in EX arrives too late.
    assign h_bex = id_compares && ex_hits_src;
    assign h_blm = id_compares && ex_mem_mem_read && mem_hits_src;
    // md_start counts too: the counter only shows busy from the next cycle.
    assign h_md  = id_is_mfhilo && (md_busy || md_start);

    assign stall = h_lu || h_bex || h_blm || h_md;

    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        id_ex_flush = 1'b0;
        if_id_flush = id_jump_taken;
        if (stall) begin
            // Freeze PC/IF_ID, inject a bubble; a redirect waits until ID
            // is no longer stalled, otherwise the stalled branch would be lost.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            if_id_flush = 1'b0;
        end
    end

    // MDU occupancy: a new start always reloads, since EX advances
    // independently of any ID stall.
    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt <= '0;
        end else if (md_start) begin
            md_cnt <= MD_W'(MD_LATENCY);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - 1'b1;
        end
    end

    assign md_busy = (md_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

    // Opcode/funct/immediate bits are irrelevant to hazard detection.
    logic unused_bits;
    assign unused_bits = ^{if_id_instruction[31:26], if_id_instruction[15:0],
                           id_ex_instruction[31:26], id_ex_instruction[10:0],
                           ex_mem_instruction[31:26], ex_mem_instruction[10:0]};

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
//   Randomized bench for hazard_unit (MD_LATENCY=4, CNT_W=4). A driver applies
//   random pipeline contents each cycle and pushes the reference model's
//   expected outputs into a queue; a monitor pops and compares each cycle.
// -----------------------------------------------------------------------------
module tb_hazard_unit;

    localparam int MD_LAT  = 4;
    localparam int CNT_W   = 4;
    localparam int N_CYC   = 3000;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic             pc_write;
        logic             if_id_write;
        logic             if_id_flush;
        logic             id_ex_flush;
        logic             md_busy;
        logic [CNT_W-1:0] stall_count;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [31:0]      if_id_instruction;
    logic             id_uses_rs, id_uses_rt, id_is_branch, id_is_jr;
    logic             id_is_mfhilo, id_jump_taken;
    logic [31:0]      id_ex_instruction;
    logic [1:0]       id_ex_gpr_w_sel;
    logic             id_ex_mem_read;
    logic [31:0]      ex_mem_instruction;
    logic [1:0]       ex_mem_gpr_w_sel;
    logic             ex_mem_mem_read;
    logic             md_start;
    logic             pc_write, if_id_write, if_id_flush, id_ex_flush, md_busy;
    logic [CNT_W-1:0] stall_count;

    exp_t exp_q[$];
    int   tests  = 0;
    int   errors = 0;

    // Reference model state: cycles of MDU work left, stalls counted so far.
    int   md_left   = 0;
    int   stalls    = 0;

    always #5 clk = ~clk;

    hazard_unit #(.MD_LATENCY(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_id_instruction(if_id_instruction),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_is_branch(id_is_branch), .id_is_jr(id_is_jr),
        .id_is_mfhilo(id_is_mfhilo), .id_jump_taken(id_jump_taken),
        .id_ex_instruction(id_ex_instruction),
        .id_ex_gpr_w_sel(id_ex_gpr_w_sel), .id_ex_mem_read(id_ex_mem_read),
        .ex_mem_instruction(ex_mem_instruction),
        .ex_mem_gpr_w_sel(ex_mem_gpr_w_sel), .ex_mem_mem_read(ex_mem_mem_read),
        .md_start(md_start),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .md_busy(md_busy), .stall_count(stall_count)
    );

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Small register pool so matches (and $0/$31 corner cases) are frequent.
    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0:       return 5'd0;
            1:       return 5'd8;
            2:       return 5'd9;
            default: return 5'd31;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0]  op   = 6'($urandom);
        logic [10:0] tail = 11'($urandom);
        return {op, pick_reg(), pick_reg(), pick_reg(), tail};
    endfunction

    // Register written by an instruction, or -1 when it writes nothing useful.
    function automatic int written(input logic [31:0] ins, input logic [1:0] sel);
        int r;
        if (sel == 2'd1)      r = int'(ins[20:16]);
        else if (sel == 2'd2) r = int'(ins[15:11]);
        else if (sel == 2'd3) r = 31;
        else                  r = -1;
        return (r == 0) ? -1 : r;
    endfunction

    function automatic bit reads(input int r);
        return r >= 0 &&
               ((id_uses_rs && r == int'(if_id_instruction[25:21])) ||
                (id_uses_rt && r == int'(if_id_instruction[20:16])));
    endfunction

    task automatic drive_random();
        rst_n              = ($urandom_range(0, 99) >= 3);
        if_id_instruction  = rand_instr();
        id_uses_rs         = 1'($urandom);
        id_uses_rt         = 1'($urandom);
        id_is_branch       = ($urandom_range(0, 3) == 0);
        id_is_jr           = ($urandom_range(0, 5) == 0);
        id_is_mfhilo       = ($urandom_range(0, 3) == 0);
        id_jump_taken      = 1'($urandom);
        id_ex_instruction  = rand_instr();
        id_ex_gpr_w_sel    = 2'($urandom);
        id_ex_mem_read     = ($urandom_range(0, 2) == 0);
        ex_mem_instruction = rand_instr();
        ex_mem_gpr_w_sel   = 2'($urandom);
        ex_mem_mem_read    = ($urandom_range(0, 2) == 0);
        md_start           = ($urandom_range(0, 9) == 0);
    endtask

    task automatic predict_and_advance();
        exp_t e;
        bit   cmp, stall;
        if (!rst_n) begin
            md_left = 0;
            stalls  = 0;
        end
        cmp   = id_is_branch || id_is_jr;
        stall = (id_ex_mem_read && reads(written(id_ex_instruction, id_ex_gpr_w_sel)))
             || (cmp && reads(written(id_ex_instruction, id_ex_gpr_w_sel)))
             || (cmp && ex_mem_mem_read && reads(written(ex_mem_instruction, ex_mem_gpr_w_sel)))
             || (id_is_mfhilo && (md_left > 0 || md_start));
        e.pc_write    = !stall;
        e.if_id_write = !stall;
        e.id_ex_flush = stall;
        e.if_id_flush = !stall && id_jump_taken;
        e.md_busy     = (md_left > 0);
        e.stall_count = CNT_W'(stalls);
        exp_q.push_back(e);
        // State after the coming rising edge (nothing moves while in reset).
        if (rst_n) begin
            if (md_start)         md_left = MD_LAT;
            else if (md_left > 0) md_left--;
            if (stall && stalls < CNT_MAX) stalls++;
        end
    endtask

    task automatic driver();
        for (int i = 0; i < N_CYC; i++) begin
            @(negedge clk);
            drive_random();
            predict_and_advance();
        end
    endtask

    task automatic monitor();
        exp_t e;
        for (int i = 0; i < N_CYC; i++) begin
            @(negedge clk);
            #2;
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 0, 1);
            end else begin
                e = exp_q.pop_front();
                check("pc_write",    int'(pc_write),    int'(e.pc_write));
                check("if_id_write", int'(if_id_write), int'(e.if_id_write));
                check("if_id_flush", int'(if_id_flush), int'(e.if_id_flush));
                check("id_ex_flush", int'(id_ex_flush), int'(e.id_ex_flush));
                check("md_busy",     int'(md_busy),     int'(e.md_busy));
                check("stall_count", int'(stall_count), int'(e.stall_count));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        if_id_instruction = '0; id_uses_rs = 0; id_uses_rt = 0;
        id_is_branch = 0; id_is_jr = 0; id_is_mfhilo = 0; id_jump_taken = 0;
        id_ex_instruction = '0; id_ex_gpr_w_sel = '0; id_ex_mem_read = 0;
        ex_mem_instruction = '0; ex_mem_gpr_w_sel = '0; ex_mem_mem_read = 0;
        md_start = 0;
        #12;
        // Reset state with idle inputs.
        check("rst_pc_write",    int'(pc_write),    1);
        check("rst_if_id_write", int'(if_id_write), 1);
        check("rst_if_id_flush", int'(if_id_flush), 0);
        check("rst_id_ex_flush", int'(id_ex_flush), 0);
        check("rst_md_busy",     int'(md_busy),     0);
        check("rst_stall_count", int'(stall_count), 0);
        fork
            driver();
            monitor();
        join
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
